// File: rtl/text_pkg.sv
// Shared types and ASCII-to-glyph mapping for the display letter-write stream.
package text_pkg;

    localparam logic [4:0] GLYPH_A      = 5'd0;
    localparam logic [4:0] GLYPH_SPACE  = 5'd26;
    localparam logic [4:0] GLYPH_PERIOD = 5'd27;
    localparam logic [4:0] GLYPH_COMMA  = 5'd28;
    localparam logic [4:0] GLYPH_QMARK  = 5'd29;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_FF = 8'h0C;

    typedef enum logic [1:0] {IDLE, EMIT, PAD, GAP} state_t;

    typedef enum logic [1:0] {KIND_GLYPH, KIND_LF, KIND_FF} kind_t;

    typedef struct packed {
        logic       valid;
        kind_t      kind;
        logic [4:0] glyph;
    } decode_t;

    // Lower case folds onto the upper-case glyphs; valid = 0 marks a byte to drop.
    function automatic decode_t ascii_to_glyph(input logic [7:0] c);
        decode_t d;
        d.valid = 1'b1;
        d.kind  = KIND_GLYPH;
        d.glyph = GLYPH_SPACE;
        if (c >= 8'h41 && c <= 8'h5A) begin
            d.glyph = GLYPH_A + 5'(c - 8'h41);
        end else if (c >= 8'h61 && c <= 8'h7A) begin
            d.glyph = GLYPH_A + 5'(c - 8'h61);
        end else begin
            case (c)
                8'h20:    d.glyph = GLYPH_SPACE;
                8'h2E:    d.glyph = GLYPH_PERIOD;
                8'h2C:    d.glyph = GLYPH_COMMA;
                8'h3F:    d.glyph = GLYPH_QMARK;
                ASCII_LF: d.kind  = KIND_LF;
                ASCII_FF: d.kind  = KIND_FF;
                default:  d.valid = 1'b0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/text_fifo.sv
// Synchronous byte FIFO with registered full/empty flags; storage is not reset.
module text_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          do_push;
    logic          do_pop;

    // A push against a full FIFO is refused even if a pop frees a slot this cycle.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == FULL_CNT);
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/text_stream_writer.sv
// Buffers ASCII bytes and emits spaced glyph write pulses to the text display.
// Define AUTO_SCROLL_EN to drive scroll_dir_out from the current write row.
module text_stream_writer #(
    parameter int FIFO_DEPTH  = 16,
    parameter int MIN_SPACING = 2,
    parameter int COLS        = 32,
    parameter int BUF_LEN     = 1024
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ascii_valid_in,
    input  logic [7:0] ascii_in,
    output logic       ascii_ready_out,
    output logic       data_valid_out,
    output logic [4:0] data_out,
    output logic [9:0] pos_out,
    output logic       busy_out,
    output logic [7:0] drop_count_out,
    output logic [1:0] scroll_dir_out
);

    import text_pkg::*;

    localparam logic [15:0] GAP_LOAD = 16'((MIN_SPACING > 2) ? MIN_SPACING - 3 : 0);

    function automatic logic [9:0] pos_inc(input logic [9:0] p);
        return (int'(p) == BUF_LEN - 1) ? 10'd0 : p + 10'd1;
    endfunction

    function automatic logic [9:0] row_end(input logic [9:0] p);
        int t;
        t = (int'(p) / COLS + 1) * COLS;
        return (t >= BUF_LEN) ? 10'd0 : 10'(t);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t      state;
    logic        padding;
    logic [9:0]  pad_target;
    logic [15:0] gap_cnt;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [7:0]  fifo_data;
    decode_t     dec_p0;
    logic        pad_more;

    text_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (ascii_valid_in),
        .push_data (ascii_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ascii_ready_out = !fifo_full;
    assign fifo_pop        = (state == IDLE) && !fifo_empty;
    assign dec_p0          = ascii_to_glyph(fifo_data);
    assign busy_out        = !fifo_empty || (state != IDLE);
    assign pad_more        = padding && (pos_inc(pos_out) != pad_target);

    // Pulse cycle is EMIT; the slot shown on pos_out during the pulse is the one written.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            padding        <= 1'b0;
            pad_target     <= '0;
            gap_cnt        <= '0;
            pos_out        <= '0;
            data_valid_out <= 1'b0;
            data_out       <= '0;
            drop_count_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (!dec_p0.valid) begin
                            drop_count_out <= sat_inc(drop_count_out);
                        end else if (dec_p0.kind == KIND_GLYPH) begin
                            data_valid_out <= 1'b1;
                            data_out       <= dec_p0.glyph;
                            state          <= EMIT;
                        end else begin
                            padding    <= 1'b1;
                            pad_target <= (dec_p0.kind == KIND_LF) ? row_end(pos_out) : 10'd0;
                            state      <= PAD;
                        end
                    end
                end
                PAD: begin
                    data_valid_out <= 1'b1;
                    data_out       <= GLYPH_SPACE;
                    state          <= EMIT;
                end
                EMIT: begin
                    data_valid_out <= 1'b0;
                    pos_out        <= pos_inc(pos_out);
                    padding        <= pad_more;
                    if (MIN_SPACING > 2) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                    end else begin
                        state <= pad_more ? PAD : IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= padding ? PAD : IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AUTO_SCROLL_EN
    assign scroll_dir_out = (int'(pos_out) / COLS >= 16) ? 2'd1 : 2'd0;
`else
    assign scroll_dir_out = 2'd0;
`endif

endmodule

// File: tb/tb_text_stream_writer.sv
// Randomized bench for text_stream_writer against a character-level reference model.
module tb_text_stream_writer;

    localparam int FIFO_DEPTH  = 16;
    localparam int MIN_SPACING = 2;
    localparam int COLS        = 32;
    localparam int BUF_LEN     = 1024;
    localparam int BOUND       = 20000;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       ascii_valid_in = 1'b0;
    logic [7:0] ascii_in = 8'h00;
    logic       ascii_ready_out;
    logic       data_valid_out;
    logic [4:0] data_out;
    logic [9:0] pos_out;
    logic       busy_out;
    logic [7:0] drop_count_out;
    logic [1:0] scroll_dir_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    text_stream_writer #(
        .FIFO_DEPTH(FIFO_DEPTH), .MIN_SPACING(MIN_SPACING), .COLS(COLS), .BUF_LEN(BUF_LEN)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .ascii_valid_in  (ascii_valid_in),
        .ascii_in        (ascii_in),
        .ascii_ready_out (ascii_ready_out),
        .data_valid_out  (data_valid_out),
        .data_out        (data_out),
        .pos_out         (pos_out),
        .busy_out        (busy_out),
        .drop_count_out  (drop_count_out),
        .scroll_dir_out  (scroll_dir_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Observed pulses: glyph, slot shown on pos_out during the pulse, cycle index.
    int mon_data[$];
    int mon_slot[$];
    int mon_cyc[$];
    always @(negedge clk_in) begin
        if (data_valid_out === 1'b1) begin
            mon_data.push_back(int'(data_out));
            mon_slot.push_back(int'(pos_out));
            mon_cyc.push_back(cyc);
        end
    end

    // Reference model: what the display should receive for each accepted byte.
    int m_pos = 0;
    int m_drop = 0;
    int exp_data[$];
    int exp_slot[$];

    task automatic m_emit(input int g);
        exp_data.push_back(g);
        exp_slot.push_back(m_pos);
        m_pos = (m_pos + 1) % BUF_LEN;
    endtask

    task automatic model_feed(input logic [7:0] b);
        int c;
        c = int'(b);
        if (c >= 65 && c <= 90)       m_emit(c - 65);
        else if (c >= 97 && c <= 122) m_emit(c - 97);
        else if (c == 32)             m_emit(26);
        else if (c == 46)             m_emit(27);
        else if (c == 44)             m_emit(28);
        else if (c == 63)             m_emit(29);
        else if (c == 10) begin
            do m_emit(26); while (m_pos % COLS != 0);
        end else if (c == 12) begin
            do m_emit(26); while (m_pos != 0);
        end else if (m_drop < 255) m_drop = m_drop + 1;
    endtask

    function automatic logic [7:0] rand_char(input bit allow_junk);
        int r;
        r = $urandom_range(0, allow_junk ? 31 : 29);
        if (r < 26) return 8'(($urandom_range(0, 1) != 0 ? 97 : 65) + r);
        case (r)
            26:      return 8'h20;
            27:      return 8'h2E;
            28:      return 8'h2C;
            29:      return 8'h3F;
            30:      return 8'h23;
            default: return 8'h7E;
        endcase
    endfunction

    task automatic clear_queues();
        mon_data.delete(); mon_slot.delete(); mon_cyc.delete();
        exp_data.delete(); exp_slot.delete();
    endtask

    task automatic send(input logic [7:0] b, output int acc_cyc);
        int waited;
        waited = 0;
        @(negedge clk_in);
        ascii_valid_in = 1'b1;
        ascii_in = b;
        while (ascii_ready_out !== 1'b1 && waited < BOUND) begin
            @(negedge clk_in);
            waited++;
        end
        acc_cyc = cyc;
        if (waited >= BOUND) begin
            checks++; failures++;
            $display("FAIL send_timeout byte=%02h ready stayed low", b);
        end else begin
            model_feed(b);
        end
        @(posedge clk_in);
        #1 ascii_valid_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk_in);
        while (busy_out !== 1'b0 && n < BOUND) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= BOUND) begin
            checks++; failures++;
            $display("FAIL wait_idle busy_out still %b after %0d cycles", busy_out, n);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        m_pos = 0; m_drop = 0;
        clear_queues();
        @(negedge clk_in);
        checks++; if (ascii_ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ascii_ready_out); end
        checks++; if (data_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", data_valid_out); end
        checks++; if (data_out !== 5'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", data_out); end
        checks++; if (pos_out !== 10'd0) begin failures++; $display("FAIL reset_pos got=%0d exp=0", pos_out); end
        checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_out); end
        checks++; if (drop_count_out !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_count_out); end
        checks++; if (scroll_dir_out !== 2'd0) begin failures++; $display("FAIL reset_scroll got=%0d exp=0", scroll_dir_out); end
    endtask

    task automatic test_hi();
        int a0, a1;
        clear_queues();
        send(8'h48, a0);
        send(8'h69, a1);
        wait_idle();
        checks++; if (a1 !== a0 + 1) begin failures++; $display("FAIL hi_accept second=%0d exp=%0d", a1, a0 + 1); end
        checks++;
        if (mon_data.size() != 2) begin
            failures++; $display("FAIL hi_count got=%0d exp=2", mon_data.size());
        end else begin
            checks++; if (mon_cyc[0] !== a0 + 2) begin failures++; $display("FAIL hi_latency got=%0d exp=%0d", mon_cyc[0], a0 + 2); end
            checks++; if (mon_cyc[1] - mon_cyc[0] !== 2) begin failures++; $display("FAIL hi_spacing got=%0d exp=2", mon_cyc[1] - mon_cyc[0]); end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (mon_data[i] !== exp_data[i] || mon_slot[i] !== exp_slot[i])
                    begin failures++; $display("FAIL hi_pulse[%0d] got=%0d@%0d exp=%0d@%0d", i, mon_data[i], mon_slot[i], exp_data[i], exp_slot[i]); end
            end
        end
        checks++; if (pos_out !== 10'd2) begin failures++; $display("FAIL hi_pos got=%0d exp=2", pos_out); end
    endtask

    task automatic test_newline();
        int a;
        int exp_pos [2];
        int exp_n [2];
        exp_pos[0] = 32; exp_pos[1] = 64;
        exp_n[0] = 27; exp_n[1] = 32;
        for (int i = 0; i < 3; i++) send(rand_char(1'b0), a);
        wait_idle();
        checks++; if (pos_out !== 10'd5) begin failures++; $display("FAIL nl_start_pos got=%0d exp=5", pos_out); end
        for (int k = 0; k < 2; k++) begin
            clear_queues();
            send(8'h0A, a);
            wait_idle();
            checks++; if (mon_data.size() != exp_n[k]) begin failures++; $display("FAIL nl_count[%0d] got=%0d exp=%0d", k, mon_data.size(), exp_n[k]); end
            for (int i = 0; i < mon_data.size() && i < exp_data.size(); i++) begin
                checks++;
                if (mon_data[i] !== exp_data[i] || mon_slot[i] !== exp_slot[i] || (i > 0 && mon_cyc[i] - mon_cyc[i-1] < MIN_SPACING))
                    begin failures++; $display("FAIL nl_pulse[%0d] got=%0d@%0d exp=%0d@%0d", i, mon_data[i], mon_slot[i], exp_data[i], exp_slot[i]); end
            end
            checks++; if (int'(pos_out) !== exp_pos[k]) begin failures++; $display("FAIL nl_pos[%0d] got=%0d exp=%0d", k, pos_out, exp_pos[k]); end
        end
    endtask

    task automatic test_drop();
        int a;
        clear_queues();
        send(8'h23, a);
        send(8'h7E, a);
        send(8'h61, a);
        wait_idle();
        checks++; if (drop_count_out !== 8'd2) begin failures++; $display("FAIL drop_count got=%0d exp=2", drop_count_out); end
        checks++;
        if (mon_data.size() != 1) begin
            failures++; $display("FAIL drop_pulses got=%0d exp=1", mon_data.size());
        end else begin
            checks++; if (mon_data[0] !== 0 || mon_slot[0] !== exp_slot[0]) begin failures++; $display("FAIL drop_glyph got=%0d@%0d exp=0@%0d", mon_data[0], mon_slot[0], exp_slot[0]); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] bytes [40];
        int a, idx, acc, first_stall, guard;
        clear_queues();
        for (int i = 0; i < 40; i++) bytes[i] = rand_char(1'b1);
        send(8'h0A, a);
        idx = 0; acc = 0; first_stall = -1; guard = 0;
        @(negedge clk_in);
        while (idx < 40 && guard < BOUND) begin
            ascii_valid_in = 1'b1;
            ascii_in = bytes[idx];
            if (ascii_ready_out === 1'b1) begin
                model_feed(bytes[idx]);
                idx++; acc++;
            end else if (first_stall < 0) begin
                first_stall = acc;
            end
            @(negedge clk_in);
            guard++;
        end
        ascii_valid_in = 1'b0;
        checks++; if (idx != 40) begin failures++; $display("FAIL bp_stream accepted=%0d exp=40", idx); end
        wait_idle();
        checks++; if (first_stall !== FIFO_DEPTH) begin failures++; $display("FAIL bp_ready_drop after=%0d exp=%0d", first_stall, FIFO_DEPTH); end
        checks++; if (mon_data.size() != exp_data.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", mon_data.size(), exp_data.size()); end
        for (int i = 0; i < mon_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (mon_data[i] !== exp_data[i] || mon_slot[i] !== exp_slot[i] || (i > 0 && mon_cyc[i] - mon_cyc[i-1] < MIN_SPACING))
                begin failures++; $display("FAIL bp_pulse[%0d] got=%0d@%0d exp=%0d@%0d", i, mon_data[i], mon_slot[i], exp_data[i], exp_slot[i]); end
        end
        checks++; if (int'(drop_count_out) !== m_drop) begin failures++; $display("FAIL bp_drop got=%0d exp=%0d", drop_count_out, m_drop); end
        checks++; if (int'(pos_out) !== m_pos) begin failures++; $display("FAIL bp_pos got=%0d exp=%0d", pos_out, m_pos); end
    endtask

    task automatic test_wrap();
        int a, n;
        if (m_pos != 0) send(8'h0C, a);
        wait_idle();
        checks++; if (pos_out !== 10'd0) begin failures++; $display("FAIL wrap_home got=%0d exp=0", pos_out); end
        clear_queues();
        for (int i = 0; i < 1023; i++) send(rand_char(1'b0), a);
        send(8'h7A, a);
        wait_idle();
        checks++; if (mon_data.size() != 1024) begin failures++; $display("FAIL wrap_count got=%0d exp=1024", mon_data.size()); end
        for (int i = 0; i < mon_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (mon_data[i] !== exp_data[i] || mon_slot[i] !== exp_slot[i])
                begin failures++; $display("FAIL wrap_pulse[%0d] got=%0d@%0d exp=%0d@%0d", i, mon_data[i], mon_slot[i], exp_data[i], exp_slot[i]); end
        end
        n = mon_data.size();
        checks++;
        if (n == 0 || mon_data[n-1] !== 25 || mon_slot[n-1] !== 1023) begin
            failures++; $display("FAIL wrap_last got=%0d@%0d exp=25@1023", (n > 0) ? mon_data[n-1] : -1, (n > 0) ? mon_slot[n-1] : -1);
        end
        checks++; if (pos_out !== 10'd0) begin failures++; $display("FAIL wrap_pos got=%0d exp=0", pos_out); end
        for (int i = 0; i < 31; i++) send(8'h0A, a);
        for (int i = 0; i < 8; i++) send(rand_char(1'b0), a);
        wait_idle();
        checks++; if (pos_out !== 10'd1000) begin failures++; $display("FAIL ff_start got=%0d exp=1000", pos_out); end
        clear_queues();
        send(8'h0C, a);
        wait_idle();
        checks++; if (mon_data.size() != 24) begin failures++; $display("FAIL ff_count got=%0d exp=24", mon_data.size()); end
        for (int i = 0; i < mon_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (mon_data[i] !== 26 || mon_slot[i] !== exp_slot[i])
                begin failures++; $display("FAIL ff_pulse[%0d] got=%0d@%0d exp=26@%0d", i, mon_data[i], mon_slot[i], exp_slot[i]); end
        end
        checks++; if (pos_out !== 10'd0) begin failures++; $display("FAIL ff_pos got=%0d exp=0", pos_out); end
    endtask

    task automatic test_scroll();
        int a;
        logic [1:0] exp_scroll;
`ifdef AUTO_SCROLL_EN
        exp_scroll = 2'd1;
`else
        exp_scroll = 2'd0;
`endif
        checks++; if (scroll_dir_out !== 2'd0) begin failures++; $display("FAIL scroll_top got=%0d exp=0", scroll_dir_out); end
        for (int i = 0; i < 16; i++) send(8'h0A, a);
        wait_idle();
        checks++; if (pos_out !== 10'd512) begin failures++; $display("FAIL scroll_pos got=%0d exp=512", pos_out); end
        checks++; if (scroll_dir_out !== exp_scroll) begin failures++; $display("FAIL scroll_dir got=%0d exp=%0d", scroll_dir_out, exp_scroll); end
    endtask

    task automatic test_reset_mid_pad();
        int a, n;
        clear_queues();
        send(8'h0A, a);
        n = 0;
        while (mon_data.size() < 5 && n < 500) begin
            @(negedge clk_in);
            n++;
        end
        checks++; if (mon_data.size() < 5) begin failures++; $display("FAIL rstpad_start pulses=%0d exp>=5", mon_data.size()); end
        checks++; if (busy_out !== 1'b1) begin failures++; $display("FAIL rstpad_busy_before got=%b exp=1", busy_out); end
        @(posedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        checks++; if (data_valid_out !== 1'b0) begin failures++; $display("FAIL rstpad_valid got=%b exp=0", data_valid_out); end
        checks++; if (pos_out !== 10'd0) begin failures++; $display("FAIL rstpad_pos got=%0d exp=0", pos_out); end
        checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL rstpad_busy got=%b exp=0", busy_out); end
        checks++; if (scroll_dir_out !== 2'd0) begin failures++; $display("FAIL rstpad_scroll got=%0d exp=0", scroll_dir_out); end
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        m_pos = 0; m_drop = 0;
        clear_queues();
        repeat (40) @(negedge clk_in);
        checks++; if (mon_data.size() != 0) begin failures++; $display("FAIL rstpad_after pulses=%0d exp=0", mon_data.size()); end
        checks++; if (pos_out !== 10'd0 || busy_out !== 1'b0) begin failures++; $display("FAIL rstpad_idle pos=%0d busy=%b exp=0/0", pos_out, busy_out); end
        checks++; if (ascii_ready_out !== 1'b1) begin failures++; $display("FAIL rstpad_ready got=%b exp=1", ascii_ready_out); end
    endtask

    initial begin
        test_reset();
        test_hi();
        test_newline();
        test_drop();
        test_backpressure();
        test_wrap();
        test_scroll();
        test_reset_mid_pad();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
